// File: rtl/stp_rcv_pkg.sv
// Shared types and default parameters for the serial receive sequencer.
package stp_rcv_pkg;

    localparam int unsigned DEF_NUM_BITS     = 8;
    localparam int unsigned DEF_CLKS_PER_BIT = 10;

    typedef enum logic [2:0] {
        IDLE,
        START_CHK,
        DATA,
        STOP,
        LOAD,
        ERR_WAIT
    } rcv_state_t;

endpackage

// File: rtl/stp_rcv_ctrl_timer.sv
// Bit-period timer: counts 0..rollover_val and wraps, flags the terminal count.
module rcv_bit_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] rollover_val,
    output logic [CNT_W-1:0] clk_cnt,
    output logic             tc
);

    assign tc = (clk_cnt == rollover_val);

    // Counter with priority clear; wraps to zero after the terminal count.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            clk_cnt <= '0;
        end else if (enable) begin
            if (tc) begin
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stp_rcv_ctrl.sv
// Receive sequencer: start-bit qualification, bit timing, shift/load strobes
// and sticky status flags for the serial-to-parallel receive path.
module stp_rcv_ctrl
    import stp_rcv_pkg::*;
#(
    parameter int unsigned NUM_BITS     = DEF_NUM_BITS,
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic serial_in,
    input  logic data_read,
    output logic shift_enable,
    output logic load_buffer,
    output logic data_ready,
    output logic framing_error,
    output logic overrun_error,
    output logic busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(NUM_BITS + 1);
    localparam int unsigned H     = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] HALF_TC  = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0] FULL_TC  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE_TC   = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NUM_BITS - 1);

    rcv_state_t       state;
    logic [BIT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] clk_cnt;
    logic             tc;
    logic             timer_clear;
    logic             timer_en;
    logic [CNT_W-1:0] rollover_val;

    // Timer runs only in timed states; half period while qualifying the start bit.
    always_comb begin
        timer_clear  = 1'b0;
        timer_en     = 1'b0;
        rollover_val = FULL_TC;
        case (state)
            START_CHK: begin
                timer_en     = 1'b1;
                rollover_val = HALF_TC;
            end
            DATA, STOP: timer_en = 1'b1;
            default:    timer_clear = 1'b1;
        endcase
    end

    rcv_bit_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .clear       (timer_clear),
        .enable      (timer_en),
        .rollover_val(rollover_val),
        .clk_cnt     (clk_cnt),
        .tc          (tc)
    );

    // Frame sequencer, bit counter, strobes and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift_enable  <= 1'b0;
            load_buffer   <= 1'b0;
            data_ready    <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            // Registered strobe: decoded one count early so it is high while clk_cnt = CLKS_PER_BIT-1.
            shift_enable <= (state == DATA) && (clk_cnt == PRE_TC);
            load_buffer  <= 1'b0;

            if (data_read && (state != LOAD)) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!serial_in) begin
                        state <= START_CHK;
                        busy  <= 1'b1;
                    end
                end
                START_CHK: begin
                    if (tc) begin
                        if (!serial_in) begin
                            state         <= DATA;
                            bit_cnt       <= '0;
                            framing_error <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (tc) begin
                        if (bit_cnt == LAST_BIT) begin
                            state   <= STOP;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tc) begin
                        if (serial_in) begin
                            state       <= LOAD;
                            load_buffer <= 1'b1;
                        end else begin
                            state         <= ERR_WAIT;
                            framing_error <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    data_ready <= 1'b1;
                    if (data_ready && !data_read) begin
                        overrun_error <= 1'b1;
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                ERR_WAIT: begin
                    if (serial_in) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stp_rcv_ctrl.sv
// Scenario bench for stp_rcv_ctrl with an attached LSB-first shift register
// and data buffer; loaded bytes are checked against a queue of sent frames.
module tb_stp_rcv_ctrl;

    localparam int NB  = 8;
    localparam int CPB = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic serial_in = 1'b1;
    logic data_read = 1'b0;
    logic shift_enable, load_buffer, data_ready, framing_error, overrun_error, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    int shift_idx = 0;
    int shift_total = 0;
    int load_total = 0;

    logic [NB-1:0] shreg = '0;
    logic [NB-1:0] buf_q = '0;
    logic [NB-1:0] exp_d;
    logic [NB-1:0] sb[$];

    stp_rcv_ctrl #(
        .NUM_BITS(NB),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .data_read    (data_read),
        .shift_enable (shift_enable),
        .load_buffer  (load_buffer),
        .data_ready   (data_ready),
        .framing_error(framing_error),
        .overrun_error(overrun_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Attached register/buffer model plus strobe timing and scoreboard checks.
    always @(negedge clk) begin
        if (shift_enable) begin
            checks++;
            if ((cyc + 1 - t0) != 15 + 10 * shift_idx) begin
                errors++;
                $display("FAIL shift_time: got cycle %0d expected %0d", cyc + 1 - t0, 15 + 10 * shift_idx);
            end
            shreg = {serial_in, shreg[NB-1:1]};
            shift_idx++;
            shift_total++;
        end
        if (load_buffer) begin
            buf_q = shreg;
            load_total++;
            checks++;
            if ((cyc + 1 - t0) != 96) begin
                errors++;
                $display("FAIL load_time: got cycle %0d expected 96", cyc + 1 - t0);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_load: got data %0h expected no load", buf_q);
            end else begin
                exp_d = sb.pop_front();
                if (buf_q !== exp_d) begin
                    errors++;
                    $display("FAIL load_data: got %0h expected %0h", buf_q, exp_d);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Advance to just after relative edge n of the current frame (bounded).
    task automatic to_edge(input int n);
        for (int i = 0; i < 500; i++) begin
            if (cyc >= t0 + n) break;
            sync();
        end
        if (cyc != t0 + n) begin
            checks++;
            errors++;
            $display("FAIL to_edge: got cycle %0d expected %0d", cyc - t0, n);
        end
    endtask

    task automatic pulse_read();
        data_read = 1'b1;
        sync();
        data_read = 1'b0;
    endtask

    // Drive one frame LSB-first; the line is left at the stop-bit level.
    task automatic send_frame(input logic [NB-1:0] d, input logic stop, input bit exp_load);
        t0 = cyc + 1;
        shift_idx = 0;
        if (exp_load) sb.push_back(d);
        serial_in = 1'b0;
        repeat (CPB) sync();
        for (int i = 0; i < NB; i++) begin
            serial_in = d[i];
            repeat (CPB) sync();
        end
        serial_in = stop;
        repeat (CPB) sync();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        serial_in = 1'b1;
        data_read = 1'b0;
        repeat (3) sync();
        checks++;
        if ({shift_enable, load_buffer, data_ready, framing_error, overrun_error, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {shift_enable, load_buffer, data_ready, framing_error, overrun_error, busy});
        end
        rst = 1'b0;
        repeat (2) sync();
    endtask

    task automatic test_frame();
        int loads0;
        loads0 = load_total;
        send_frame(8'hA5, 1'b1, 1'b1);
        repeat (2) sync();
        checks++;
        if (load_total != loads0 + 1) begin
            errors++;
            $display("FAIL frame_load_count: got %0d expected %0d", load_total - loads0, 1);
        end
        checks++;
        if (shift_idx != NB) begin
            errors++;
            $display("FAIL frame_shift_count: got %0d expected %0d", shift_idx, NB);
        end
        checks++;
        if ({data_ready, framing_error, overrun_error, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL frame_flags: got %b expected 1000", {data_ready, framing_error, overrun_error, busy});
        end
        pulse_read();
        checks++;
        if (data_ready !== 1'b0) begin
            errors++;
            $display("FAIL read_clear: got %b expected 0", data_ready);
        end
    endtask

    task automatic test_glitch();
        int shifts0;
        shifts0 = shift_total;
        t0 = cyc + 1;
        shift_idx = 0;
        serial_in = 1'b0;
        repeat (3) sync();
        serial_in = 1'b1;
        to_edge(4);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_hold: got %b expected 1", busy);
        end
        to_edge(5);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_idle: got %b expected 0", busy);
        end
        repeat (20) sync();
        checks++;
        if (shift_total != shifts0) begin
            errors++;
            $display("FAIL glitch_no_shift: got %0d expected %0d", shift_total - shifts0, 0);
        end
    endtask

    task automatic test_framing_error();
        int shifts0;
        int loads0;
        loads0 = load_total;
        send_frame(8'h0F, 1'b0, 1'b0);
        checks++;
        if ({framing_error, busy, data_ready} !== 3'b110) begin
            errors++;
            $display("FAIL ferr_set: got %b expected 110", {framing_error, busy, data_ready});
        end
        shifts0 = shift_total;
        repeat (20) sync();
        checks++;
        if (busy !== 1'b1 || shift_total != shifts0 || load_total != loads0) begin
            errors++;
            $display("FAIL ferr_wait: got busy=%b shifts=%0d loads=%0d expected busy=1 shifts=0 loads=0",
                     busy, shift_total - shifts0, load_total - loads0);
        end
        serial_in = 1'b1;
        repeat (2) sync();
        checks++;
        if ({busy, framing_error} !== 2'b01) begin
            errors++;
            $display("FAIL ferr_release: got %b expected 01", {busy, framing_error});
        end
        fork
            send_frame(8'h96, 1'b1, 1'b1);
            begin
                #2;
                to_edge(4);
                checks++;
                if (framing_error !== 1'b1) begin
                    errors++;
                    $display("FAIL ferr_sticky: got %b expected 1", framing_error);
                end
                to_edge(5);
                checks++;
                if (framing_error !== 1'b0) begin
                    errors++;
                    $display("FAIL ferr_clear_on_start: got %b expected 0", framing_error);
                end
            end
        join
        repeat (2) sync();
        checks++;
        if (data_ready !== 1'b1) begin
            errors++;
            $display("FAIL ferr_next_frame: got %b expected 1", data_ready);
        end
        pulse_read();
    endtask

    task automatic test_back_to_back();
        send_frame(8'h3C, 1'b1, 1'b1);
        send_frame(8'hC3, 1'b1, 1'b1);
        repeat (2) sync();
        checks++;
        if ({data_ready, overrun_error} !== 2'b11) begin
            errors++;
            $display("FAIL overrun_set: got %b expected 11", {data_ready, overrun_error});
        end
        pulse_read();
        checks++;
        if ({data_ready, overrun_error} !== 2'b00) begin
            errors++;
            $display("FAIL overrun_clear: got %b expected 00", {data_ready, overrun_error});
        end
    endtask

    task automatic test_read_collision();
        send_frame(8'h11, 1'b1, 1'b1);
        fork
            send_frame(8'hE7, 1'b1, 1'b1);
            begin
                #2;
                to_edge(95);
                data_read = 1'b1;
                sync();
                data_read = 1'b0;
            end
        join
        repeat (2) sync();
        checks++;
        if ({data_ready, overrun_error} !== 2'b10) begin
            errors++;
            $display("FAIL read_collision: got %b expected 10", {data_ready, overrun_error});
        end
    endtask

    task automatic test_reset_mid();
        logic [NB-1:0] d;
        int loads0;
        d = 8'h69;
        loads0 = load_total;
        t0 = cyc + 1;
        shift_idx = 0;
        serial_in = 1'b0;
        repeat (CPB) sync();
        for (int i = 0; i < 3; i++) begin
            serial_in = d[i];
            repeat (CPB) sync();
        end
        serial_in = d[3];
        rst = 1'b1;
        sync();
        rst = 1'b0;
        serial_in = 1'b1;
        checks++;
        if ({shift_enable, load_buffer, data_ready, framing_error, overrun_error, busy} !== 6'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b expected 000000",
                     {shift_enable, load_buffer, data_ready, framing_error, overrun_error, busy});
        end
        repeat (20) sync();
        checks++;
        if (load_total != loads0 || shift_idx != 3) begin
            errors++;
            $display("FAIL midreset_abort: got loads=%0d shifts=%0d expected loads=0 shifts=3",
                     load_total - loads0, shift_idx);
        end
        send_frame(8'h5A, 1'b1, 1'b1);
        repeat (2) sync();
        checks++;
        if ({data_ready, framing_error, overrun_error} !== 3'b100) begin
            errors++;
            $display("FAIL midreset_next_frame: got %b expected 100", {data_ready, framing_error, overrun_error});
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_glitch();
        test_framing_error();
        test_back_to_back();
        test_read_collision();
        test_reset_mid();
        repeat (5) sync();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_loads: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
